// File: rtl/cell_stim_sequencer.sv
// cell_stim_sequencer: exhaustive stimulus and truth-table checker for one standard cell under test.
// Ports: wb_clk_i/wb_rst_i clock and async reset; start/abort control; n_inputs/settle/out_mask/exp_tt run config;
// cell_in/cell_out connection to the cell under test; busy/done/pass/err_count/first_fail_* run results.
module cell_stim_sequencer #(
  parameter int N_IN = 4,
  parameter int N_OUT = 2,
  parameter int SETTLE_W = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start,
  input  logic                       abort,
  input  logic [2:0]                 n_inputs,
  input  logic [SETTLE_W-1:0]        settle,
  input  logic [N_OUT-1:0]           out_mask,
  input  logic [N_OUT*(2**N_IN)-1:0] exp_tt,
  output logic [N_IN-1:0]            cell_in,
  input  logic [N_OUT-1:0]           cell_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_count,
  output logic [N_IN-1:0]            first_fail_vec,
  output logic                       first_fail_valid
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [N_IN-1:0] vec, last_vec, last_n;
  logic [SETTLE_W:0] cnt;
  logic [SETTLE_W-1:0] settle_r;
  logic [N_OUT-1:0] mask_r, s1, s2;
  logic go, mism;
  int n_eff;
  assign go = start && (state == IDLE || state == DONE);
  assign busy = state == SETTLE || state == SAMPLE;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  assign cell_in = vec;
  always_comb begin
    n_eff = (int'(n_inputs) > N_IN) ? N_IN : int'(n_inputs);
    last_n = N_IN'((1 << n_eff) - 1);
    mism = |((s2 ^ exp_tt[N_OUT*int'(vec) +: N_OUT]) & mask_r);
    state_n = abort ? IDLE :
              go ? SETTLE :
              (state == SETTLE && cnt == '0) ? SAMPLE :
              (state == SAMPLE) ? ((vec == last_vec) ? DONE : SETTLE) : state;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i || abort) begin
      vec <= '0;
      last_vec <= '0;
      cnt <= '0;
      settle_r <= '0;
      mask_r <= '0;
      s1 <= '0;
      s2 <= '0;
      err_count <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      s1 <= cell_out;
      s2 <= s1;
      if (go) begin
        vec <= '0;
        last_vec <= last_n;
        settle_r <= settle;
        mask_r <= out_mask;
        cnt <= {1'b0, settle} + {{SETTLE_W{1'b0}}, 1'b1};
        err_count <= '0;
        first_fail_vec <= '0;
        first_fail_valid <= 1'b0;
      end else if (state == SETTLE) begin
        if (cnt != '0) cnt <= cnt - {{SETTLE_W{1'b0}}, 1'b1};
      end else if (state == SAMPLE) begin
        if (mism) err_count <= err_count + (N_IN+1)'(1);
        if (mism && !first_fail_valid) begin
          first_fail_vec <= vec;
          first_fail_valid <= 1'b1;
        end
        if (vec != last_vec) begin
          vec <= vec + N_IN'(1);
          cnt <= {1'b0, settle_r} + {{SETTLE_W{1'b0}}, 1'b1};
        end
      end
    end
  end
endmodule
